// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory stage of the 16-bit pipeline.
//   DATA_W / REG_W  : datapath and register-index widths
//   RW_REG / RW_R0  : bit positions inside the 2-bit reg_write field
//   mem_fsm_e       : access-latency wait FSM states
//   ex_mem_t        : EX/MEM pipeline register contents
package mem_stage_pkg;

   localparam int DATA_W = 16;
   localparam int REG_W  = 4;
   localparam int RW_W   = 2;
   localparam int RW_REG = 0;   // write write_reg
   localparam int RW_R0  = 1;   // write r0

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_fsm_e;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] r0_result;
      logic [DATA_W-1:0] store_data;
      logic [REG_W-1:0]  write_reg;
      logic [RW_W-1:0]   reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              byte_enable;
   } ex_mem_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX -> MEM inputs and MEM -> EX/hazard/WB outputs of the memory stage.
//   master : the execute side / environment (drives ex_*, observes results)
//   slave  : mem_stage itself
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic              ex_valid;
   logic [DATA_W-1:0] ex_alu_result;
   logic [DATA_W-1:0] ex_r0_result;
   logic [DATA_W-1:0] ex_store_data;
   logic [REG_W-1:0]  ex_write_reg;
   logic [RW_W-1:0]   ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_byte_enable;

   logic              mem_hold;
   logic [DATA_W-1:0] mem_ex_forwarded_alu_output;
   logic [REG_W-1:0]  mem_write_reg;
   logic [RW_W-1:0]   mem_reg_write;
   logic              mem_is_load;
   logic              wb_valid;
   logic [DATA_W-1:0] wb_write_data;
   logic [DATA_W-1:0] wb_r0;
   logic [REG_W-1:0]  wb_write_reg;
   logic [RW_W-1:0]   wb_reg_write;

   modport master (
      output ex_valid, ex_alu_result, ex_r0_result, ex_store_data, ex_write_reg,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_byte_enable,
      input  mem_hold, mem_ex_forwarded_alu_output, mem_write_reg, mem_reg_write,
             mem_is_load, wb_valid, wb_write_data, wb_r0, wb_write_reg, wb_reg_write
   );

   modport slave (
      input  ex_valid, ex_alu_result, ex_r0_result, ex_store_data, ex_write_reg,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_byte_enable,
      output mem_hold, mem_ex_forwarded_alu_output, mem_write_reg, mem_reg_write,
             mem_is_load, wb_valid, wb_write_data, wb_r0, wb_write_reg, wb_reg_write
   );

endinterface

// File: rtl/mem_stage_data_memory.sv
// data_memory: byte-addressable big-endian data RAM.
//   clock   : write clock
//   addr    : byte address (already reduced modulo MEM_BYTES)
//   byte_en : 1 = byte access, 0 = word access (addr[0] ignored)
//   we      : write enable
//   wdata   : store data (byte store uses wdata[7:0])
//   rdata   : combinational read; byte reads are sign-extended
module data_memory #(
   parameter int MEM_BYTES = 256
) (
   input  logic                         clock,
   input  logic [$clog2(MEM_BYTES)-1:0] addr,
   input  logic                         byte_en,
   input  logic                         we,
   input  logic [15:0]                  wdata,
   output logic [15:0]                  rdata
);

   localparam int AW = $clog2(MEM_BYTES);

   logic [7:0]    mem [MEM_BYTES];
   logic [AW-1:0] even_a;
   logic [AW-1:0] odd_a;

   // Word pairs are always even-aligned, so the pair never straddles the wrap point.
   assign even_a = {addr[AW-1:1], 1'b0};
   assign odd_a  = {addr[AW-1:1], 1'b1};

   always_comb begin
      if (byte_en) rdata = {{8{mem[addr][7]}}, mem[addr]};
      else         rdata = {mem[even_a], mem[odd_a]};
   end

   always_ff @(posedge clock) begin
      if (we) begin
         if (byte_en) begin
            mem[addr] <= wdata[7:0];
         end else begin
            mem[even_a] <= wdata[15:8];
            mem[odd_a]  <= wdata[7:0];
         end
      end
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 16-bit five-stage pipeline.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset (memory contents are kept)
//   bus   : ex_* inputs from EX; mem_* forwarding/hold outputs; wb_* MEM/WB register
// Holds the EX/MEM register, a LATENCY-cycle wait FSM for loads/stores, the data
// memory and the MEM/WB register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int MEM_BYTES = 256,
   parameter int LATENCY   = 0
) (
   input  logic       clock,
   input  logic       reset,
   mem_stage_if.slave bus
);

   localparam int            AW       = $clog2(MEM_BYTES);
   localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

   ex_mem_t           ex_mem_q;
   mem_fsm_e          state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              hold;
   logic              mem_op;
   logic              is_load;
   logic              store_en;
   logic [DATA_W-1:0] load_data;

   logic              wb_valid_q;
   logic [DATA_W-1:0] wb_data_q;
   logic [DATA_W-1:0] wb_r0_q;
   logic [REG_W-1:0]  wb_wreg_q;
   logic [RW_W-1:0]   wb_rw_q;

   // read+write together behaves as a store
   assign mem_op   = ex_mem_q.valid & (ex_mem_q.mem_read | ex_mem_q.mem_write);
   assign is_load  = ex_mem_q.valid & ex_mem_q.mem_read & ~ex_mem_q.mem_write;
   // Only the completion edge writes, so a multi-cycle store lands exactly once.
   assign store_en = ex_mem_q.valid & ex_mem_q.mem_write & ~hold;

   // EX/MEM pipeline register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_mem_q <= '0;
      end else if (!hold) begin
         ex_mem_q.valid       <= bus.ex_valid;
         ex_mem_q.alu_result  <= bus.ex_alu_result;
         ex_mem_q.r0_result   <= bus.ex_r0_result;
         ex_mem_q.store_data  <= bus.ex_store_data;
         ex_mem_q.write_reg   <= bus.ex_write_reg;
         ex_mem_q.reg_write   <= bus.ex_reg_write;
         ex_mem_q.mem_read    <= bus.ex_mem_read;
         ex_mem_q.mem_write   <= bus.ex_mem_write;
         ex_mem_q.byte_enable <= bus.ex_byte_enable;
      end
   end

   // Wait FSM: state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Wait FSM: next state (stays IDLE when LATENCY is 0)
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (LATENCY != 0) begin
         case (state_q)
            ST_IDLE: begin
               if (mem_op) begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
               else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Wait FSM: outputs
   always_comb begin
      hold = 1'b0;
      if (LATENCY != 0) begin
         case (state_q)
            ST_IDLE: hold = mem_op;
            ST_WAIT: hold = (cnt_q != '0);
            default: hold = 1'b0;
         endcase
      end
   end

   data_memory #(
      .MEM_BYTES (MEM_BYTES)
   ) u_dmem (
      .clock   (clock),
      .addr    (ex_mem_q.alu_result[AW-1:0]),
      .byte_en (ex_mem_q.byte_enable),
      .we      (store_en),
      .wdata   (ex_mem_q.store_data),
      .rdata   (load_data)
   );

   // MEM/WB pipeline register; a bubble is inserted while the access is pending
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_r0_q    <= '0;
         wb_wreg_q  <= '0;
         wb_rw_q    <= '0;
      end else if (hold) begin
         wb_valid_q <= 1'b0;
         wb_rw_q    <= '0;
      end else begin
         wb_valid_q <= ex_mem_q.valid;
         wb_data_q  <= is_load ? load_data : ex_mem_q.alu_result;
         wb_r0_q    <= ex_mem_q.r0_result;
         wb_wreg_q  <= ex_mem_q.write_reg;
         wb_rw_q    <= ex_mem_q.reg_write & {RW_W{ex_mem_q.valid}};
      end
   end

   assign bus.mem_hold                    = hold;
   assign bus.mem_ex_forwarded_alu_output = ex_mem_q.alu_result;
   assign bus.mem_write_reg               = ex_mem_q.write_reg;
   assign bus.mem_reg_write               = ex_mem_q.reg_write & {RW_W{ex_mem_q.valid}};
   assign bus.mem_is_load                 = is_load;
   assign bus.wb_valid                    = wb_valid_q;
   assign bus.wb_write_data               = wb_data_q;
   assign bus.wb_r0                       = wb_r0_q;
   assign bus.wb_write_reg                = wb_wreg_q;
   assign bus.wb_reg_write                = wb_rw_q & {RW_W{wb_valid_q}};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with LATENCY 0, 2 and 3 instances.
// One stimulus set drives whichever instance sel selects (ex_valid is gated per
// instance); observed outputs are muxed back by sel.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;

   logic [1:0]  sel;
   logic        drv_valid, drv_rd, drv_wr, drv_be;
   logic [15:0] drv_alu, drv_r0, drv_sd;
   logic [3:0]  drv_wreg;
   logic [1:0]  drv_rw;

   logic        obs_hold, obs_isload, obs_wbv;
   logic [15:0] obs_fwd, obs_wbd, obs_wbr0;
   logic [3:0]  obs_mwreg, obs_wbwreg;
   logic [1:0]  obs_mrw, obs_wbrw;

   mem_stage_if if0 ();
   mem_stage_if if2 ();
   mem_stage_if if3 ();

   mem_stage #(.MEM_BYTES(256), .LATENCY(0)) dut0 (.clock(clock), .reset(reset), .bus(if0));
   mem_stage #(.MEM_BYTES(256), .LATENCY(2)) dut2 (.clock(clock), .reset(reset), .bus(if2));
   mem_stage #(.MEM_BYTES(256), .LATENCY(3)) dut3 (.clock(clock), .reset(reset), .bus(if3));

   assign if0.ex_valid = drv_valid & (sel == 2'd0);
   assign if2.ex_valid = drv_valid & (sel == 2'd2);
   assign if3.ex_valid = drv_valid & (sel == 2'd3);
   assign if0.ex_alu_result = drv_alu;  assign if2.ex_alu_result = drv_alu;  assign if3.ex_alu_result = drv_alu;
   assign if0.ex_r0_result  = drv_r0;   assign if2.ex_r0_result  = drv_r0;   assign if3.ex_r0_result  = drv_r0;
   assign if0.ex_store_data = drv_sd;   assign if2.ex_store_data = drv_sd;   assign if3.ex_store_data = drv_sd;
   assign if0.ex_write_reg  = drv_wreg; assign if2.ex_write_reg  = drv_wreg; assign if3.ex_write_reg  = drv_wreg;
   assign if0.ex_reg_write  = drv_rw;   assign if2.ex_reg_write  = drv_rw;   assign if3.ex_reg_write  = drv_rw;
   assign if0.ex_mem_read   = drv_rd;   assign if2.ex_mem_read   = drv_rd;   assign if3.ex_mem_read   = drv_rd;
   assign if0.ex_mem_write  = drv_wr;   assign if2.ex_mem_write  = drv_wr;   assign if3.ex_mem_write  = drv_wr;
   assign if0.ex_byte_enable = drv_be;  assign if2.ex_byte_enable = drv_be;  assign if3.ex_byte_enable = drv_be;

   always_comb begin
      case (sel)
         2'd2: begin
            obs_hold = if2.mem_hold; obs_fwd = if2.mem_ex_forwarded_alu_output;
            obs_mwreg = if2.mem_write_reg; obs_mrw = if2.mem_reg_write; obs_isload = if2.mem_is_load;
            obs_wbv = if2.wb_valid; obs_wbd = if2.wb_write_data; obs_wbr0 = if2.wb_r0;
            obs_wbwreg = if2.wb_write_reg; obs_wbrw = if2.wb_reg_write;
         end
         2'd3: begin
            obs_hold = if3.mem_hold; obs_fwd = if3.mem_ex_forwarded_alu_output;
            obs_mwreg = if3.mem_write_reg; obs_mrw = if3.mem_reg_write; obs_isload = if3.mem_is_load;
            obs_wbv = if3.wb_valid; obs_wbd = if3.wb_write_data; obs_wbr0 = if3.wb_r0;
            obs_wbwreg = if3.wb_write_reg; obs_wbrw = if3.wb_reg_write;
         end
         default: begin
            obs_hold = if0.mem_hold; obs_fwd = if0.mem_ex_forwarded_alu_output;
            obs_mwreg = if0.mem_write_reg; obs_mrw = if0.mem_reg_write; obs_isload = if0.mem_is_load;
            obs_wbv = if0.wb_valid; obs_wbd = if0.wb_write_data; obs_wbr0 = if0.wb_r0;
            obs_wbwreg = if0.wb_write_reg; obs_wbrw = if0.wb_reg_write;
         end
      endcase
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] r0,
                        input logic [15:0] sd, input logic [3:0] wreg, input logic [1:0] rw,
                        input logic rd, input logic wr, input logic be);
      drv_valid = v; drv_alu = alu; drv_r0 = r0; drv_sd = sd;
      drv_wreg = wreg; drv_rw = rw; drv_rd = rd; drv_wr = wr; drv_be = be;
   endtask

   task automatic bubble();
      drive(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // ---- reset with random inputs ----
      reset = 1'b0;
      sel   = 2'd0;
      drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
            2'($urandom), 1'b1, 1'b0, 1'($urandom));
      step();
      step();
      check("rst_hold",    16'(obs_hold),   16'h0);
      check("rst_fwd",     obs_fwd,         16'h0);
      check("rst_mwreg",   16'(obs_mwreg),  16'h0);
      check("rst_mrw",     16'(obs_mrw),    16'h0);
      check("rst_isload",  16'(obs_isload), 16'h0);
      check("rst_wbv",     16'(obs_wbv),    16'h0);
      check("rst_wbd",     obs_wbd,         16'h0);
      check("rst_wbr0",    obs_wbr0,        16'h0);
      check("rst_wbwreg",  16'(obs_wbwreg), 16'h0);
      check("rst_wbrw",    16'(obs_wbrw),   16'h0);
      check("rst_hold2",   16'(if2.mem_hold), 16'h0);
      check("rst_hold3",   16'(if3.mem_hold), 16'h0);
      bubble();
      reset = 1'b1;
      step();
      check("post_rst_wbv", 16'(obs_wbv), 16'h0);
      check("post_rst_fwd", obs_fwd,      16'h0);

      // ---- LATENCY=0: word store then word load ----
      drive(1'b1, 16'h0010, 16'h0, 16'hBEEF, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      check("l0_st_hold", 16'(obs_hold), 16'h0);
      drive(1'b1, 16'h0010, 16'h0, 16'h0, 4'h3, 2'b01, 1'b1, 1'b0, 1'b0);
      step();
      check("l0_ld_isload", 16'(obs_isload), 16'h1);
      check("l0_ld_fwd",    obs_fwd,         16'h0010);
      check("l0_ld_mrw",    16'(obs_mrw),    16'h1);
      bubble();
      step();
      check("l0_ld_wbv",    16'(obs_wbv),    16'h1);
      check("l0_ld_wbd",    obs_wbd,         16'hBEEF);
      check("l0_ld_wbwreg", 16'(obs_wbwreg), 16'h3);
      check("l0_ld_wbrw",   16'(obs_wbrw),   16'h1);

      // ---- byte store 0x80 @0x11, then byte/word loads ----
      drive(1'b1, 16'h0011, 16'h0, 16'h7F80, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1);
      step();
      drive(1'b1, 16'h0011, 16'h0, 16'h0, 4'h4, 2'b01, 1'b1, 1'b0, 1'b1);
      step();
      drive(1'b1, 16'h0010, 16'h0, 16'h0, 4'h4, 2'b01, 1'b1, 1'b0, 1'b1);
      step();
      check("lb_0011", obs_wbd, 16'hFF80);
      drive(1'b1, 16'h0011, 16'h0, 16'h0, 4'h4, 2'b01, 1'b1, 1'b0, 1'b0);
      step();
      check("lb_0010", obs_wbd, 16'hFFBE);
      bubble();
      step();
      check("lw_0011", obs_wbd, 16'hBE80);

      // ---- LATENCY=2: store 0xBE80 @0x10, then load + held ALU op ----
      sel = 2'd2;
      drive(1'b1, 16'h0010, 16'h0, 16'hBE80, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      check("l2_st_hold_c1", 16'(obs_hold), 16'h1);
      bubble();
      step();
      check("l2_st_hold_c2", 16'(obs_hold), 16'h1);
      step();
      check("l2_st_hold_c3", 16'(obs_hold), 16'h0);
      step();
      drive(1'b1, 16'h0010, 16'h0, 16'h0, 4'h6, 2'b01, 1'b1, 1'b0, 1'b0);
      step();
      check("l2_ld_hold_c1", 16'(obs_hold), 16'h1);
      check("l2_ld_wbv_c1",  16'(obs_wbv),  16'h0);
      drive(1'b1, 16'h1234, 16'h0001, 16'h0, 4'h5, 2'b11, 1'b0, 1'b0, 1'b0);
      step();
      check("l2_ld_hold_c2", 16'(obs_hold), 16'h1);
      check("l2_ld_wbv_c2",  16'(obs_wbv),  16'h0);
      check("l2_alu_held",   obs_fwd,       16'h0010);
      step();
      check("l2_ld_hold_c3", 16'(obs_hold), 16'h0);
      check("l2_ld_wbv_c3",  16'(obs_wbv),  16'h0);
      check("l2_alu_held2",  obs_fwd,       16'h0010);
      step();
      check("l2_ld_wbv",     16'(obs_wbv),    16'h1);
      check("l2_ld_wbd",     obs_wbd,         16'hBE80);
      check("l2_ld_wbwreg",  16'(obs_wbwreg), 16'h6);
      check("alu_fwd",       obs_fwd,         16'h1234);
      check("alu_mrw",       16'(obs_mrw),    16'h3);
      check("alu_mwreg",     16'(obs_mwreg),  16'h5);
      check("alu_no_hold",   16'(obs_hold),   16'h0);
      bubble();
      step();
      check("alu_wbd",    obs_wbd,         16'h1234);
      check("alu_wbr0",   obs_wbr0,        16'h0001);
      check("alu_wbwreg", 16'(obs_wbwreg), 16'h5);
      check("alu_wbrw",   16'(obs_wbrw),   16'h3);

      // ---- LATENCY=3: store 0x5555 @0x20, then reset during a 0xAAAA store ----
      sel = 2'd3;
      drive(1'b1, 16'h0020, 16'h0, 16'h5555, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      check("l3_hold_c1", 16'(obs_hold), 16'h1);
      bubble();
      step();
      check("l3_hold_c2", 16'(obs_hold), 16'h1);
      step();
      check("l3_hold_c3", 16'(obs_hold), 16'h1);
      step();
      check("l3_hold_c4", 16'(obs_hold), 16'h0);
      step();
      drive(1'b1, 16'h0020, 16'h0, 16'hAAAA, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      bubble();
      step();
      check("l3_wait_hold", 16'(obs_hold), 16'h1);
      reset = 1'b0;
      #1;
      check("l3_rst_hold", 16'(obs_hold), 16'h0);
      check("l3_rst_fwd",  obs_fwd,       16'h0);
      check("l3_rst_wbv",  16'(obs_wbv),  16'h0);
      check("l3_rst_wbd",  obs_wbd,       16'h0);
      step();
      reset = 1'b1;
      step();
      check("l3_idle_hold", 16'(obs_hold), 16'h0);
      drive(1'b1, 16'h0020, 16'h0, 16'h0, 4'h7, 2'b01, 1'b1, 1'b0, 1'b0);
      step();
      check("l3_ld_hold", 16'(obs_hold), 16'h1);
      bubble();
      step();
      step();
      step();
      check("l3_ld_wbv_pre", 16'(obs_wbv), 16'h0);
      step();
      check("l3_ld_wbv",    16'(obs_wbv),    16'h1);
      check("l3_ld_old",    obs_wbd,         16'h5555);
      check("l3_ld_wbwreg", 16'(obs_wbwreg), 16'h7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
